// File: rtl/buffer_sched_pkg.sv
// buffer_sched_pkg
//   Shared types and constants for the pattern-buffer scheduler.
//   - sched_state_t : scheduler states (IDLE, PLAY, WRITE)
//   - NO_BUFS, BUFFER_SIZE, BUFFER_WIDTH : bank geometry
//   - buf_onehot / field_onehot : index to one-hot select
//   - lowest_onehot : lowest set bit of a buffer mask as one-hot
//   - eff_len : effective per-buffer playback length
package buffer_sched_pkg;

    localparam int NO_BUFS      = 8;
    localparam int BUFFER_SIZE  = 22;
    localparam int BUFFER_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        WRITE = 2'd2
    } sched_state_t;

    function automatic logic [NO_BUFS-1:0] buf_onehot(input logic [2:0] idx);
        logic [NO_BUFS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Indices at or beyond BUFFER_SIZE decode to all-zero.
    function automatic logic [BUFFER_SIZE-1:0] field_onehot(input logic [4:0] idx);
        logic [BUFFER_SIZE-1:0] oh;
        oh = '0;
        for (int i = 0; i < BUFFER_SIZE; i++) begin
            if (idx == 5'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    function automatic logic [NO_BUFS-1:0] lowest_onehot(input logic [NO_BUFS-1:0] mask);
        logic [NO_BUFS-1:0] oh;
        oh = '0;
        for (int i = NO_BUFS - 1; i >= 0; i--) begin
            if (mask[i]) oh = buf_onehot(3'(i));
        end
        return oh;
    endfunction

    // Zero length still plays one field; anything past the buffer is clipped.
    function automatic logic [4:0] eff_len(input logic [4:0] len);
        if (len == 5'd0)
            return 5'd1;
        else if (len > 5'(BUFFER_SIZE))
            return 5'(BUFFER_SIZE);
        else
            return len;
    endfunction

endpackage

// File: rtl/onehot_rr_next.sv
// onehot_rr_next
//   Combinational round-robin step over a one-hot buffer select.
//   cur     : current one-hot buffer
//   enable  : buffers allowed in the rotation
//   nxt_sel : next enabled buffer above cur (circular); cur itself when it is
//             the only one enabled; cur unchanged when enable is empty
//   wrap    : rotation wrapped (next index <= current index)
module onehot_rr_next
    import buffer_sched_pkg::*;
(
    input  logic [NO_BUFS-1:0] cur,
    input  logic [NO_BUFS-1:0] enable,
    output logic [NO_BUFS-1:0] nxt_sel,
    output logic               wrap
);

    logic [2:0] cur_idx;
    logic [2:0] nxt_idx;
    logic [2:0] cand;
    logic       found;

    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < NO_BUFS; i++) begin
            if (cur[i]) cur_idx = 3'(i);
        end
        found   = 1'b0;
        nxt_idx = cur_idx;
        cand    = '0;
        // k = NO_BUFS truncates back to cur_idx, covering the single-buffer case.
        for (int k = 1; k <= NO_BUFS; k++) begin
            cand = cur_idx + 3'(k);
            if (!found && enable[cand]) begin
                found   = 1'b1;
                nxt_idx = cand;
            end
        end
        nxt_sel = found ? buf_onehot(nxt_idx) : cur;
        wrap    = found && (nxt_idx <= cur_idx);
    end

endmodule

// File: rtl/buffer_sched.sv
// buffer_sched
//   Playback sequencer and write arbiter for the 8-instance pattern buffer bank.
//   Inputs : clk, rst (sync, active high), start, stop, buf_enable, buf_len,
//            wr_req/wr_buf/wr_field/wr_data (level request held until ack/err)
//   Outputs: buffer_select (one-hot playback buffer), bufp (read/write buffer),
//            fieldp..fieldp4 (one-hot read field, fanout copies), fieldwp,
//            field_in, field_write, wr_ack, wr_err, busy, wrap. All registered.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no playback; fieldp* = 0, selects hold; writes accepted directly
//   PLAY  | one field per cycle through enabled buffers
//   WRITE | single-cycle field write; playback registers frozen
module buffer_sched
    import buffer_sched_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [NO_BUFS-1:0]      buf_enable,
    input  logic [4:0]              buf_len,
    input  logic                    wr_req,
    input  logic [2:0]              wr_buf,
    input  logic [4:0]              wr_field,
    input  logic [BUFFER_WIDTH-1:0] wr_data,
    output logic                    wr_ack,
    output logic                    wr_err,
    output logic [NO_BUFS-1:0]      buffer_select,
    output logic [NO_BUFS-1:0]      bufp,
    output logic [BUFFER_SIZE-1:0]  fieldp,
    output logic [BUFFER_SIZE-1:0]  fieldp2,
    output logic [BUFFER_SIZE-1:0]  fieldp3,
    output logic [BUFFER_SIZE-1:0]  fieldp4,
    output logic [BUFFER_SIZE-1:0]  fieldwp,
    output logic [BUFFER_WIDTH-1:0] field_in,
    output logic                    field_write,
    output logic                    busy,
    output logic                    wrap
);

    localparam logic [BUFFER_SIZE-1:0] FIELD_FIRST = BUFFER_SIZE'(1);
    localparam logic [NO_BUFS-1:0]     BUF_FIRST   = NO_BUFS'(1);

    sched_state_t       state;
    logic [4:0]         field_cnt;   // fields left in current buffer, 0 = last
    logic               wr_block;    // a write finished; one PLAY step owed
    logic [NO_BUFS-1:0] adv_sel;
    logic               adv_wrap;
    logic               wr_take;
    logic               do_write;
    logic               do_err;
    logic [BUFFER_SIZE-1:0] field_step;

    onehot_rr_next u_rr (
        .cur     (buffer_select),
        .enable  (buf_enable),
        .nxt_sel (adv_sel),
        .wrap    (adv_wrap)
    );

    // A registered wr_err means the request on wr_req this cycle is the one
    // already answered, so it must not be taken a second time.
    always_comb begin
        wr_take    = wr_req && !wr_err &&
                     ((state == IDLE) || ((state == PLAY) && !wr_block));
        do_write   = wr_take && (wr_field < 5'(BUFFER_SIZE));
        do_err     = wr_take && !(wr_field < 5'(BUFFER_SIZE));
        field_step = fieldp << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            field_cnt     <= '0;
            wr_block      <= 1'b0;
            buffer_select <= BUF_FIRST;
            bufp          <= BUF_FIRST;
            fieldp        <= '0;
            fieldp2       <= '0;
            fieldp3       <= '0;
            fieldp4       <= '0;
            fieldwp       <= '0;
            field_in      <= '0;
            field_write   <= 1'b0;
            wr_ack        <= 1'b0;
            wr_err        <= 1'b0;
            busy          <= 1'b0;
            wrap          <= 1'b0;
        end else begin
            field_write <= 1'b0;
            wr_ack      <= 1'b0;
            wr_err      <= 1'b0;
            wrap        <= 1'b0;

            if (stop) begin
                // Selects hold so the bank keeps a valid one-hot decode.
                state    <= IDLE;
                busy     <= 1'b0;
                wr_block <= 1'b0;
                fieldp   <= '0;
                fieldp2  <= '0;
                fieldp3  <= '0;
                fieldp4  <= '0;
                fieldwp  <= '0;
            end else if (do_write) begin
                state       <= WRITE;
                busy        <= 1'b1;
                wr_block    <= 1'b1;
                bufp        <= buf_onehot(wr_buf);
                fieldwp     <= field_onehot(wr_field);
                field_in    <= wr_data;
                field_write <= 1'b1;
                wr_ack      <= 1'b1;
            end else begin
                if (do_err) wr_err <= 1'b1;

                case (state)
                    IDLE: begin
                        if (start && (|buf_enable)) begin
                            state         <= PLAY;
                            busy          <= 1'b1;
                            wr_block      <= 1'b0;
                            buffer_select <= lowest_onehot(buf_enable);
                            bufp          <= lowest_onehot(buf_enable);
                            fieldp        <= FIELD_FIRST;
                            fieldp2       <= FIELD_FIRST;
                            fieldp3       <= FIELD_FIRST;
                            fieldp4       <= FIELD_FIRST;
                            field_cnt     <= eff_len(buf_len) - 5'd1;
                        end
                    end

                    PLAY: begin
                        wr_block <= 1'b0;
                        if (field_cnt != 5'd0) begin
                            fieldp    <= field_step;
                            fieldp2   <= field_step;
                            fieldp3   <= field_step;
                            fieldp4   <= field_step;
                            field_cnt <= field_cnt - 5'd1;
                        end else if (|buf_enable) begin
                            buffer_select <= adv_sel;
                            bufp          <= adv_sel;
                            wrap          <= adv_wrap;
                            fieldp        <= FIELD_FIRST;
                            fieldp2       <= FIELD_FIRST;
                            fieldp3       <= FIELD_FIRST;
                            fieldp4       <= FIELD_FIRST;
                            field_cnt     <= eff_len(buf_len) - 5'd1;
                        end else begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            fieldp  <= '0;
                            fieldp2 <= '0;
                            fieldp3 <= '0;
                            fieldp4 <= '0;
                        end
                    end

                    WRITE: begin
                        // The exit cycle does not step playback; the owed PLAY
                        // step (wr_block) follows before another write.
                        bufp    <= buffer_select;
                        fieldwp <= '0;
                        if (|fieldp) begin
                            state <= PLAY;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_buffer_sched.sv
// tb_buffer_sched
//   Self-checking bench for buffer_sched. Expected playback and write results
//   are pushed to queues from a small reference model when stimulus is driven
//   and popped when the DUT presents them.
module tb_buffer_sched;

    logic        clk, rst, start, stop, wr_req;
    logic        wr_ack, wr_err, field_write, busy, wrap;
    logic [7:0]  buf_enable, buffer_select, bufp, wr_data, field_in;
    logic [4:0]  buf_len, wr_field;
    logic [2:0]  wr_buf;
    logic [21:0] fieldp, fieldp2, fieldp3, fieldp4, fieldwp;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [7:0] sel; logic [21:0] fp; logic wr; } play_exp_t;
    typedef struct { logic [7:0] bp; logic [21:0] fwp; logic [7:0] data; } wr_exp_t;

    play_exp_t play_q[$];
    wr_exp_t   wr_q[$];

    buffer_sched dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .buf_enable    (buf_enable),
        .buf_len       (buf_len),
        .wr_req        (wr_req),
        .wr_buf        (wr_buf),
        .wr_field      (wr_field),
        .wr_data       (wr_data),
        .wr_ack        (wr_ack),
        .wr_err        (wr_err),
        .buffer_select (buffer_select),
        .bufp          (bufp),
        .fieldp        (fieldp),
        .fieldp2       (fieldp2),
        .fieldp3       (fieldp3),
        .fieldp4       (fieldp4),
        .fieldwp       (fieldwp),
        .field_in      (field_in),
        .field_write   (field_write),
        .busy          (busy),
        .wrap          (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; wr_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reference playback model: expected outputs for n cycles after start.
    task automatic push_play(input logic [7:0] mask, input logic [4:0] len, input int n);
        int cur, fidx, l, nx;
        logic fnd;
        play_exp_t e;
        l = (len == 0) ? 1 : ((len > 22) ? 22 : int'(len));
        cur = 0;
        while (cur < 7 && !mask[cur]) cur++;
        fidx = 0;
        for (int k = 0; k < n; k++) begin
            e.wr = 1'b0;
            if (k > 0) begin
                if (fidx == l - 1) begin
                    nx = cur;
                    fnd = 1'b0;
                    for (int j = 1; j <= 8; j++) begin
                        if (!fnd && mask[(cur + j) % 8]) begin
                            nx = (cur + j) % 8;
                            fnd = 1'b1;
                        end
                    end
                    e.wr = (nx <= cur);
                    cur = nx;
                    fidx = 0;
                end else begin
                    fidx++;
                end
            end
            e.sel = 8'(1) << cur;
            e.fp  = 22'(1) << fidx;
            play_q.push_back(e);
        end
    endtask

    task automatic push_write();
        wr_exp_t w;
        w.bp   = 8'(1) << wr_buf;
        w.fwp  = 22'(1) << wr_field;
        w.data = wr_data;
        wr_q.push_back(w);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; buf_enable = 8'hFF; wr_req = 1'b1; wr_field = 5'd3;
        tick();
        tick();
        checks++;
        if (buffer_select !== 8'h01 || bufp !== 8'h01) begin
            errors++;
            $display("FAIL reset_sel buffer_select=%h bufp=%h expected 01/01", buffer_select, bufp);
        end
        checks++;
        if ({fieldp, fieldp2, fieldp3, fieldp4} !== '0) begin
            errors++;
            $display("FAIL reset_fieldp fieldp=%h expected 0", fieldp);
        end
        checks++;
        if (fieldwp !== '0 || field_in !== 8'h00 || field_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_write fieldwp=%h field_in=%h field_write=%b expected 0", fieldwp, field_in, field_write);
        end
        checks++;
        if ({wr_ack, wr_err, busy, wrap} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags ack/err/busy/wrap=%b expected 0000", {wr_ack, wr_err, busy, wrap});
        end
        rst = 1'b0; start = 1'b0; wr_req = 1'b0; buf_enable = 8'h00;
    endtask

    task automatic test_playback();
        play_exp_t e;
        do_reset();
        buf_enable = 8'h05; buf_len = 5'd3;
        push_play(8'h05, 5'd3, 9);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) tick();
            e = play_q.pop_front();
            checks++;
            if (buffer_select !== e.sel || bufp !== e.sel) begin
                errors++;
                $display("FAIL play_sel cyc %0d buffer_select=%h bufp=%h expected %h", k, buffer_select, bufp, e.sel);
            end
            checks++;
            if ({fieldp, fieldp2, fieldp3, fieldp4} !== {4{e.fp}}) begin
                errors++;
                $display("FAIL play_field cyc %0d fieldp=%h/%h/%h/%h expected %h", k, fieldp, fieldp2, fieldp3, fieldp4, e.fp);
            end
            checks++;
            if (wrap !== e.wr || busy !== 1'b1) begin
                errors++;
                $display("FAIL play_wrap cyc %0d wrap=%b busy=%b expected %b/1", k, wrap, busy, e.wr);
            end
        end
    endtask

    task automatic test_idle_misc();
        wr_exp_t w;
        do_reset();
        buf_enable = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || fieldp !== '0 || buffer_select !== 8'h01) begin
            errors++;
            $display("FAIL start_no_enable busy=%b fieldp=%h sel=%h expected 0/0/01", busy, fieldp, buffer_select);
        end
        wr_req = 1'b1; wr_buf = 3'd3; wr_field = 5'd0; wr_data = 8'h3C;
        push_write();
        tick();
        wr_req = 1'b0;
        w = wr_q.pop_front();
        checks++;
        if (wr_ack !== 1'b1 || field_write !== 1'b1 || bufp !== w.bp || fieldwp !== w.fwp || field_in !== w.data) begin
            errors++;
            $display("FAIL idle_write ack=%b fw=%b bufp=%h fieldwp=%h in=%h expected 1/1/%h/%h/%h",
                     wr_ack, field_write, bufp, fieldwp, field_in, w.bp, w.fwp, w.data);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || bufp !== 8'h01 || field_write !== 1'b0 || wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL idle_write_exit busy=%b bufp=%h fw=%b ack=%b expected 0/01/0/0", busy, bufp, field_write, wr_ack);
        end
    endtask

    task automatic test_write_stall();
        wr_exp_t w;
        bit got;
        do_reset();
        buf_enable = 8'h02; buf_len = 5'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (fieldp !== 22'h4 || buffer_select !== 8'h02) begin
            errors++;
            $display("FAIL stall_pre fieldp=%h sel=%h expected 4/02", fieldp, buffer_select);
        end
        wr_req = 1'b1; wr_buf = 3'd5; wr_field = 5'd7; wr_data = 8'hA5;
        push_write();
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            tick();
            if (wr_ack === 1'b1 || wr_err === 1'b1) got = 1'b1;
        end
        wr_req = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL stall_ack_timeout ack not seen within 8 cycles expected ack");
        end else begin
            w = wr_q.pop_front();
            if (bufp !== w.bp || fieldwp !== w.fwp || field_in !== w.data || field_write !== 1'b1 || wr_ack !== 1'b1) begin
                errors++;
                $display("FAIL stall_write bufp=%h fieldwp=%h in=%h fw=%b ack=%b expected %h/%h/%h/1/1",
                         bufp, fieldwp, field_in, field_write, wr_ack, w.bp, w.fwp, w.data);
            end
            checks++;
            if (fieldp !== 22'h4 || buffer_select !== 8'h02 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold fieldp=%h sel=%h busy=%b expected 4/02/1", fieldp, buffer_select, busy);
            end
        end
        tick();
        checks++;
        if (bufp !== 8'h02 || field_write !== 1'b0 || wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL stall_restore bufp=%h fw=%b ack=%b expected 02/0/0", bufp, field_write, wr_ack);
        end
        tick();
        checks++;
        if (fieldp !== 22'h8) begin
            errors++;
            $display("FAIL stall_resume fieldp=%h expected 8", fieldp);
        end
    endtask

    task automatic test_back_to_back();
        wr_exp_t w;
        int n_acks, steps;
        bit done;
        logic [29:0] prev;
        do_reset();
        buf_enable = 8'h0F; buf_len = 5'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        prev = {buffer_select, fieldp};
        wr_req = 1'b1; wr_buf = 3'd0; wr_field = 5'd1; wr_data = 8'h10;
        push_write();
        n_acks = 0; steps = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            if ({buffer_select, fieldp} !== prev) steps++;
            prev = {buffer_select, fieldp};
            if (wr_err === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL b2b_err wr_err=1 expected 0");
            end
            if (wr_ack === 1'b1) begin
                n_acks++;
                w = wr_q.pop_front();
                checks++;
                if (bufp !== w.bp || fieldwp !== w.fwp || field_in !== w.data) begin
                    errors++;
                    $display("FAIL b2b_data #%0d bufp=%h fieldwp=%h in=%h expected %h/%h/%h",
                             n_acks, bufp, fieldwp, field_in, w.bp, w.fwp, w.data);
                end
                if (n_acks > 1) begin
                    checks++;
                    if (steps != 1) begin
                        errors++;
                        $display("FAIL b2b_alternate #%0d play steps between writes=%0d expected 1", n_acks, steps);
                    end
                end
                steps = 0;
                if (n_acks < 4) begin
                    wr_buf = 3'(n_acks + 4); wr_field = 5'(n_acks * 5 + 1); wr_data = 8'(8'h10 + n_acks);
                    push_write();
                end else begin
                    wr_req = 1'b0;
                    done = 1'b1;
                end
            end
        end
        wr_req = 1'b0;
        checks++;
        if (n_acks != 4) begin
            errors++;
            $display("FAIL b2b_count acks=%0d expected 4", n_acks);
        end
        wr_q.delete();
    endtask

    task automatic test_wr_err();
        do_reset();
        buf_enable = 8'h02; buf_len = 5'd22;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        wr_req = 1'b1; wr_buf = 3'd1; wr_field = 5'd22; wr_data = 8'hEE;
        tick();
        wr_req = 1'b0;
        checks++;
        if (wr_err !== 1'b1 || wr_ack !== 1'b0 || field_write !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse err=%b ack=%b fw=%b expected 1/0/0", wr_err, wr_ack, field_write);
        end
        checks++;
        if (fieldp !== 22'h4 || bufp !== 8'h02) begin
            errors++;
            $display("FAIL err_no_stall fieldp=%h bufp=%h expected 4/02", fieldp, bufp);
        end
        tick();
        checks++;
        if (wr_err !== 1'b0 || fieldp !== 22'h8) begin
            errors++;
            $display("FAIL err_after err=%b fieldp=%h expected 0/8", wr_err, fieldp);
        end
    endtask

    task automatic test_len();
        logic [7:0] masks[2];
        logic [4:0] lens[2];
        int         ncyc[2];
        play_exp_t  e;
        masks[0] = 8'h05; lens[0] = 5'd0;  ncyc[0] = 6;
        masks[1] = 8'h01; lens[1] = 5'd31; ncyc[1] = 24;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            buf_enable = masks[t]; buf_len = lens[t];
            push_play(masks[t], lens[t], ncyc[t]);
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int k = 0; k < ncyc[t]; k++) begin
                if (k > 0) tick();
                e = play_q.pop_front();
                checks++;
                if (buffer_select !== e.sel || fieldp !== e.fp || wrap !== e.wr) begin
                    errors++;
                    $display("FAIL len_%0d cyc %0d sel=%h fieldp=%h wrap=%b expected %h/%h/%b",
                             t, k, buffer_select, fieldp, wrap, e.sel, e.fp, e.wr);
                end
            end
        end
    endtask

    task automatic test_stop_rst();
        do_reset();
        buf_enable = 8'h09; buf_len = 5'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (buffer_select !== 8'h08 || fieldp !== 22'h1) begin
            errors++;
            $display("FAIL stop_pre sel=%h fieldp=%h expected 08/1", buffer_select, fieldp);
        end
        stop = 1'b1; wr_req = 1'b1; wr_buf = 3'd6; wr_field = 5'd2; wr_data = 8'h77;
        tick();
        stop = 1'b0; wr_req = 1'b0;
        checks++;
        if (busy !== 1'b0 || {fieldp, fieldp2, fieldp3, fieldp4} !== '0) begin
            errors++;
            $display("FAIL stop_idle busy=%b fieldp=%h expected 0/0", busy, fieldp);
        end
        checks++;
        if (buffer_select !== 8'h08 || bufp !== 8'h08 || wr_ack !== 1'b0 || field_write !== 1'b0) begin
            errors++;
            $display("FAIL stop_hold sel=%h bufp=%h ack=%b fw=%b expected 08/08/0/0", buffer_select, bufp, wr_ack, field_write);
        end
        tick();
        checks++;
        if (buffer_select !== 8'h08 || busy !== 1'b0 || wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL stop_stay sel=%h busy=%b ack=%b expected 08/0/0", buffer_select, busy, wr_ack);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        wr_req = 1'b1; wr_buf = 3'd6; wr_field = 5'd4; wr_data = 8'h5A;
        tick();
        checks++;
        if (field_write !== 1'b1 || bufp !== 8'h40) begin
            errors++;
            $display("FAIL rst_pre_write fw=%b bufp=%h expected 1/40", field_write, bufp);
        end
        rst = 1'b1; start = 1'b1;
        tick();
        checks++;
        if (buffer_select !== 8'h01 || bufp !== 8'h01 || fieldp !== '0 || fieldwp !== '0 || field_in !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_write sel=%h bufp=%h fieldp=%h fieldwp=%h in=%h expected 01/01/0/0/0",
                     buffer_select, bufp, fieldp, fieldwp, field_in);
        end
        checks++;
        if ({field_write, wr_ack, wr_err, busy, wrap} !== 5'b00000) begin
            errors++;
            $display("FAIL rst_mid_write_flags fw/ack/err/busy/wrap=%b expected 00000",
                     {field_write, wr_ack, wr_err, busy, wrap});
        end
        rst = 1'b0; start = 1'b0; wr_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; wr_req = 1'b0;
        buf_enable = 8'h00; buf_len = 5'd0;
        wr_buf = 3'd0; wr_field = 5'd0; wr_data = 8'h00;
        test_reset();
        test_playback();
        test_idle_misc();
        test_write_stall();
        test_back_to_back();
        test_wr_err();
        test_len();
        test_stop_rst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
